// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle for pipe_stage_buf: an upstream channel (in_*) and a
// downstream channel (out_*).
// valid/ready rule for both channels: a transfer happens on a falling clock
// edge where valid and ready are both 1; once valid is raised, the source
// keeps valid and its payload steady until that transfer happens, and valid
// never depends on ready.
// slave  : the buffer side (takes in_*, drives out_*).
// master : the environment side (drives in_*, takes out_*).
interface pipe_stage_buf_if #(
  parameter int DATA_W = 112,
  parameter int CTRL_W = 40
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: pipeline stage buffer between two valid/ready channels,
// all state updated on the falling edge of clk, async active-high reset.
// Optional feature macro PIPE_STAGE_BUF_SKID_EN:
//   defined   -> two entries (main + skid), in_ready is a register.
//   undefined -> main entry only, in_ready = !out_valid | out_ready.
// out_ctrl is masked to zero whenever no entry is held (bubble), while
// out_data keeps the last main payload.
module pipe_stage_buf #(
  parameter int DATA_W = 112,
  parameter int CTRL_W = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  pipe_stage_buf_if.slave bus,
  output logic [1:0]  count,
  output logic [15:0] stall_cycles,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [15:0]       stall_q;
  logic              push, pop;
  logic              load_main_in;
  logic              in_ready_int;

`ifdef PIPE_STAGE_BUF_SKID_EN
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              in_ready_q;
  logic              load_skid;
  logic              load_main_skid;

  assign in_ready_int = in_ready_q;
`else
  // Single entry: room exists when empty or when the head leaves this edge.
  assign in_ready_int = (state_q == S_EMPTY) | bus.out_ready;
`endif

  assign push = bus.in_valid & in_ready_int;
  assign pop  = (state_q != S_EMPTY) & bus.out_ready;

  // Next-state and load selects; flush overrides every transfer.
  always_comb begin
    state_d      = state_q;
    load_main_in = 1'b0;
`ifdef PIPE_STAGE_BUF_SKID_EN
    load_skid      = 1'b0;
    load_main_skid = 1'b0;
`endif
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push) begin
            state_d      = S_ONE;
            load_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            load_main_in = 1'b1;
          end else if (push) begin
`ifdef PIPE_STAGE_BUF_SKID_EN
            state_d   = S_FULL;
            load_skid = 1'b1;
`endif
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
`ifdef PIPE_STAGE_BUF_SKID_EN
          if (pop) begin
            state_d        = S_ONE;
            load_main_skid = 1'b1;
          end
`else
          state_d = S_EMPTY;
`endif
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  // Main entry: loaded from the input or promoted from the skid entry.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      main_data <= '0;
      main_ctrl <= '0;
    end else if (load_main_in) begin
      main_data <= bus.in_data;
      main_ctrl <= bus.in_ctrl;
`ifdef PIPE_STAGE_BUF_SKID_EN
    end else if (load_main_skid) begin
      main_data <= skid_data;
      main_ctrl <= skid_ctrl;
`endif
    end
  end

`ifdef PIPE_STAGE_BUF_SKID_EN
  // Skid entry catches the push that arrives while the head is blocked.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (load_skid) begin
      skid_data <= bus.in_data;
      skid_ctrl <= bus.in_ctrl;
    end
  end

  // in_ready registered from the next state so out_ready never reaches it.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) in_ready_q <= 1'b1;
    else       in_ready_q <= (state_d != S_FULL);
  end
`endif

  // Saturating back-pressure counter, cleared only by reset.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (!flush && (state_q != S_EMPTY) && !bus.out_ready &&
                 (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = (state_q != S_EMPTY);
  assign bus.out_data  = main_data;
  assign bus.out_ctrl  = (state_q != S_EMPTY) ? main_ctrl : '0;
  assign count         = state_q;
  assign stall_cycles  = stall_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Testbench for pipe_stage_buf (default build or PIPE_STAGE_BUF_SKID_EN).
// Inputs are driven just after the rising edge; outputs are sampled 1ns later,
// well away from the active falling edge. Pushed entries go into exp_q and
// are popped and compared when the DUT hands them downstream.
module tb_pipe_stage_buf;
  localparam int DATA_W = 112;
  localparam int CTRL_W = 40;
  localparam int EW     = DATA_W + CTRL_W;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [1:0]  count;
  logic [15:0] stall_cycles;
  logic [1:0]  state_dbg;

  pipe_stage_buf_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

  pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .bus          (bus.slave),
    .count        (count),
    .stall_cycles (stall_cycles),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]     exp_q[$];
  logic [15:0]       m_stall;
  logic [DATA_W-1:0] m_main;
  int                n_checks;
  int                n_errors;

  task automatic check(input string tag, input logic [159:0] got,
                       input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_in_ready(input logic ordy);
`ifdef PIPE_STAGE_BUF_SKID_EN
    return (exp_q.size() < 2);
`else
    return (exp_q.size() == 0) || ordy;
`endif
  endfunction

  task automatic check_status();
    logic [EW-1:0] head;
    check("count", 160'(count), 160'(exp_q.size()));
    check("out_valid", 160'(bus.out_valid), 160'(exp_q.size() > 0));
    check("in_ready", 160'(bus.in_ready), 160'(exp_in_ready(bus.out_ready)));
    check("stall_cycles", 160'(stall_cycles), 160'(m_stall));
    if (exp_q.size() > 0) begin
      head = exp_q[0];
      check("head_data", 160'(bus.out_data), 160'(head[EW-1:CTRL_W]));
      check("head_ctrl", 160'(bus.out_ctrl), 160'(head[CTRL_W-1:0]));
    end else begin
      check("idle_data", 160'(bus.out_data), 160'(m_main));
      check("idle_ctrl", 160'(bus.out_ctrl), 160'(0));
    end
  endtask

  // After an edge the main entry is the queue head, or unchanged if empty.
  task automatic track_main();
    logic [EW-1:0] head;
    if (exp_q.size() > 0) begin
      head   = exp_q[0];
      m_main = head[EW-1:CTRL_W];
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic iv, input logic [DATA_W-1:0] d,
                       input logic [CTRL_W-1:0] c, input logic ordy,
                       input logic fl);
    logic          v, push, pop;
    logic [EW-1:0] e;
    @(posedge clk);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    check_status();
    v    = (exp_q.size() > 0);
    push = iv && exp_in_ready(ordy);
    pop  = v && ordy;
    if (pop && !fl) begin
      e = exp_q.pop_front();
      check("pop_data", 160'(bus.out_data), 160'(e[EW-1:CTRL_W]));
      check("pop_ctrl", 160'(bus.out_ctrl), 160'(e[CTRL_W-1:0]));
    end
    @(negedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (v && !ordy && m_stall != 16'hFFFF) m_stall++;
      if (push) exp_q.push_back({d, c});
    end
    track_main();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, '0, ordy, 1'b0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_stall = '0;
    m_main  = '0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_status();
    #1 reset = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DATA_W-1:0];
  endfunction

  function automatic logic [CTRL_W-1:0] rand_ctrl();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[CTRL_W-1:0];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [EW-1:0] e;
    n_checks = 0;
    n_errors = 0;
    model_reset();
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_ctrl   = '0;
    bus.out_ready = 1'b0;
    #3;
    check_status();
    check("reset_in_ready", 160'(bus.in_ready), 160'(1));
    #20 reset = 1'b0;

    // Single entry through an open pipe.
    cycle(1'b1, DATA_W'(16'h1234), CTRL_W'(4'h5), 1'b1, 1'b0);
    check("lat_valid", 160'(exp_q.size()), 160'(1));
    idle(1'b1);
    idle(1'b1);

    // Back-pressure: A then B while blocked, then drain.
    cycle(1'b1, DATA_W'(8'h11), CTRL_W'(1), 1'b0, 1'b0);
    cycle(1'b1, DATA_W'(8'h22), CTRL_W'(2), 1'b0, 1'b0);
`ifndef PIPE_STAGE_BUF_SKID_EN
    // B was refused; upstream holds it until the head leaves.
    cycle(1'b1, DATA_W'(8'h22), CTRL_W'(2), 1'b1, 1'b0);
`endif
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Stall counting while blocked, then flush with a simultaneous push.
    pulse_reset();
    cycle(1'b1, DATA_W'(8'h33), CTRL_W'(3), 1'b0, 1'b0);
    cycle(1'b1, DATA_W'(8'h44), CTRL_W'(4), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);
    cycle(1'b1, DATA_W'(8'h55), CTRL_W'(5), 1'b0, 1'b1);
    idle(1'b0);
    check("flush_stall_kept", 160'(stall_cycles), 160'(m_stall));

    // Streaming 0..99 with an always-ready sink.
    pulse_reset();
    for (int i = 0; i < 100; i++)
      cycle(1'b1, DATA_W'(i), CTRL_W'(i + 1), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("stream_stall_zero", 160'(stall_cycles), 160'(0));

`ifndef PIPE_STAGE_BUF_SKID_EN
    // Combinational in_ready follows out_ready within a cycle.
    cycle(1'b1, DATA_W'(8'h66), CTRL_W'(6), 1'b0, 1'b0);
    @(posedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("comb_rdy_low", 160'(bus.in_ready), 160'(0));
    bus.out_ready = 1'b1;
    #1;
    check("comb_rdy_high", 160'(bus.in_ready), 160'(1));
    e = exp_q.pop_front();
    check("comb_pop_data", 160'(bus.out_data), 160'(e[EW-1:CTRL_W]));
    @(negedge clk);
    track_main();
    idle(1'b1);
`endif

    // Randomised traffic with occasional flush.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), rand_data(), rand_ctrl(),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0));
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Asynchronous reset while holding entries, between clock edges.
    cycle(1'b1, DATA_W'(8'h77), CTRL_W'(7), 1'b0, 1'b0);
    cycle(1'b1, DATA_W'(8'h88), CTRL_W'(8), 1'b0, 1'b0);
    @(posedge clk);
    bus.in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_status();
    check("async_rst_data", 160'(bus.out_data), 160'(0));
    check("async_rst_rdy", 160'(bus.in_ready), 160'(1));
    #1 reset = 1'b0;

    // First push after reset goes through normally.
    cycle(1'b1, DATA_W'(8'h99), CTRL_W'(9), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
